// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial transmitter between two character sources,
// primes the transmitter flag after reset and holds load until acceptance.
module tx_arbiter #(
    parameter bit          FIXED_PRI    = 1'b0,
    parameter bit          LOCK_EN      = 1'b1,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd65535
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        clear,
    input  logic        r0_valid,
    input  logic        r1_valid,
    input  logic [0:7]  r0_char,
    input  logic [0:7]  r1_char,
    input  logic        r0_last,
    input  logic        r1_last,
    output logic        r0_ready,
    output logic        r1_ready,
    output logic        r0_done,
    output logic        r1_done,
    output logic [0:11] tx_char,
    output logic        tx_load,
    output logic        tx_set_flag,
    input  logic        tx_flag,
    output logic        busy,
    output logic        owner,
    output logic        lock
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [0:7]  hold_q, hold_d;
    logic        owner_q, owner_d;
    logic        lock_q, lock_d;
    logic        rr_q, rr_d;
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic        tx_load_q, tx_load_d;
    logic        tx_set_flag_q, tx_set_flag_d;
    logic        busy_q, busy_d;
    logic        r0_done_q, r0_done_d;
    logic        r1_done_q, r1_done_d;

    logic cand0, cand1, pick1, grant_en, owner_valid;

    // rr_q names the preferred requester; a done cycle blocks new grants.
    always_comb begin
        cand0       = r0_valid & (~lock_q | ~owner_q);
        cand1       = r1_valid & (~lock_q | owner_q);
        pick1       = cand1 & (~cand0 | (~FIXED_PRI & rr_q));
        grant_en    = (state_q == S_IDLE) & ~r0_done_q & ~r1_done_q;
        r0_ready    = grant_en & cand0 & ~pick1;
        r1_ready    = grant_en & pick1;
        owner_valid = owner_q ? r1_valid : r0_valid;
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        r0_done_d  = 1'b0;
        r1_done_d  = 1'b0;
        case (state_q)
            S_INIT:  state_d = S_PRIME;
            S_PRIME: if (tx_flag) state_d = S_IDLE;
            S_IDLE: begin
                if (r1_ready) begin
                    hold_d     = r1_char;
                    owner_d    = 1'b1;
                    lock_d     = LOCK_EN & ~r1_last;
                    lock_cnt_d = 16'd0;
                    state_d    = S_LOAD;
                end else if (r0_ready) begin
                    hold_d     = r0_char;
                    owner_d    = 1'b0;
                    lock_d     = LOCK_EN & ~r0_last;
                    lock_cnt_d = 16'd0;
                    state_d    = S_LOAD;
                end else if (lock_q & ~owner_valid) begin
                    if (lock_cnt_q + 16'd1 == LOCK_TIMEOUT) begin
                        lock_d     = 1'b0;
                        lock_cnt_d = 16'd0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 16'd1;
                    end
                end
            end
            S_LOAD: if (~tx_flag) state_d = S_SEND;
            S_SEND: begin
                if (tx_flag) begin
                    r0_done_d = ~owner_q;
                    r1_done_d = owner_q;
                    rr_d      = ~owner_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
        tx_load_d     = (state_d == S_LOAD);
        tx_set_flag_d = (state_q == S_INIT);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk100) begin
        if (reset | clear) begin
            state_q       <= S_INIT;
            hold_q        <= '0;
            owner_q       <= 1'b0;
            lock_q        <= 1'b0;
            rr_q          <= 1'b0;
            lock_cnt_q    <= 16'd0;
            tx_load_q     <= 1'b0;
            tx_set_flag_q <= 1'b0;
            busy_q        <= 1'b1;
            r0_done_q     <= 1'b0;
            r1_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            owner_q       <= owner_d;
            lock_q        <= lock_d;
            rr_q          <= rr_d;
            lock_cnt_q    <= lock_cnt_d;
            tx_load_q     <= tx_load_d;
            tx_set_flag_q <= tx_set_flag_d;
            busy_q        <= busy_d;
            r0_done_q     <= r0_done_d;
            r1_done_q     <= r1_done_d;
        end
    end

    assign tx_char     = {4'b0000, hold_q};
    assign tx_load     = tx_load_q;
    assign tx_set_flag = tx_set_flag_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign lock        = lock_q;
    assign r0_done     = r0_done_q;
    assign r1_done     = r1_done_q;

endmodule
